// File: rtl/phase_to_rgb_pipe.sv
// Three-stage streaming mapper from phase angle plus brightness to RGB (hue wheel or gray ramp).
// One global enable stalls every stage together while the output is held.
module phase_to_rgb_pipe #(
    parameter int unsigned PHASE_W   = 9,
    parameter int unsigned PHASE_MAX = 360,
    parameter int unsigned COLOR_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PHASE_W-1:0] in_phase,
    input  logic [COLOR_W-1:0] in_value,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COLOR_W-1:0] out_red,
    output logic [COLOR_W-1:0] out_green,
    output logic [COLOR_W-1:0] out_blue,
    output logic               err_range
);

    localparam int unsigned CMAX   = (1 << COLOR_W) - 1;
    localparam int unsigned PROD_W = PHASE_W + COLOR_W;
    localparam int unsigned EXT_W  = COLOR_W + 2;
    localparam int unsigned MUL_W  = 2 * COLOR_W;
    localparam int unsigned SEG    = CMAX / 3;

    logic en;

    // Stage 1 registers
    logic               v1_q;
    logic [COLOR_W-1:0] s1_q;
    logic [COLOR_W-1:0] val1_q;
    logic               mode1_q;

    // Stage 2 registers
    logic               v2_q;
    logic [COLOR_W-1:0] r2_q, g2_q, b2_q;
    logic [COLOR_W-1:0] val2_q;

    // Stage 1 combinational
    logic               in_range;
    logic [PHASE_W-1:0] p_clamped;
    logic [PROD_W-1:0]  p_scaled;
    logic [COLOR_W-1:0] s_d;

    // Stage 2 combinational
    logic [EXT_W-1:0]   s_ext, off, tri_v, up, down;
    logic [1:0]         seg;
    logic [COLOR_W-1:0] r_d, g_d, b_d;

    always_comb begin
        en       = !out_valid || out_ready;
        in_ready = en;
    end

    // Compare at 32 bits so PHASE_MAX == 2^PHASE_W still works.
    always_comb begin
        in_range  = 32'(in_phase) < PHASE_MAX;
        p_clamped = in_range ? in_phase : PHASE_W'(PHASE_MAX - 1);
        p_scaled  = (PROD_W'(p_clamped) * PROD_W'(CMAX)) / PROD_W'(PHASE_MAX);
        s_d       = COLOR_W'(p_scaled);
    end

    always_comb begin
        s_ext = EXT_W'(s1_q);
        if (s_ext < EXT_W'(SEG)) begin
            seg = 2'd0;
            off = s_ext;
        end else if (s_ext < EXT_W'(2 * SEG)) begin
            seg = 2'd1;
            off = s_ext - EXT_W'(SEG);
        end else begin
            seg = 2'd2;
            off = s_ext - EXT_W'(2 * SEG);
        end
        tri_v = off * EXT_W'(3);
        up    = (tri_v > EXT_W'(CMAX)) ? EXT_W'(CMAX) : tri_v;
        down  = (tri_v >= EXT_W'(CMAX)) ? '0 : EXT_W'(CMAX) - tri_v;

        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (mode1_q) begin
            r_d = s1_q;
            g_d = s1_q;
            b_d = s1_q;
        end else begin
            case (seg)
                2'd0: begin
                    r_d = COLOR_W'(down);
                    g_d = COLOR_W'(up);
                end
                2'd1: begin
                    g_d = COLOR_W'(down);
                    b_d = COLOR_W'(up);
                end
                default: begin
                    b_d = COLOR_W'(down);
                    r_d = COLOR_W'(up);
                end
            endcase
        end
    end

    // value == CMAX returns c exactly since c*CMAX/CMAX == c.
    function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                                 input logic [COLOR_W-1:0] v);
        logic [MUL_W-1:0] prod;
        prod = MUL_W'(c) * MUL_W'(v);
        return COLOR_W'(prod / MUL_W'(CMAX));
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            s1_q      <= '0;
            val1_q    <= '0;
            mode1_q   <= 1'b0;
            v2_q      <= 1'b0;
            r2_q      <= '0;
            g2_q      <= '0;
            b2_q      <= '0;
            val2_q    <= '0;
            out_valid <= 1'b0;
            out_red   <= '0;
            out_green <= '0;
            out_blue  <= '0;
            err_range <= 1'b0;
        end else begin
            if (in_valid && en && !in_range) begin
                err_range <= 1'b1;
            end
            if (en) begin
                v1_q      <= in_valid;
                s1_q      <= s_d;
                val1_q    <= in_value;
                mode1_q   <= in_mode;
                v2_q      <= v1_q;
                r2_q      <= r_d;
                g2_q      <= g_d;
                b2_q      <= b_d;
                val2_q    <= val1_q;
                out_valid <= v2_q;
                out_red   <= scale(r2_q, val2_q);
                out_green <= scale(g2_q, val2_q);
                out_blue  <= scale(b2_q, val2_q);
            end
        end
    end

endmodule

// File: tb/tb_phase_to_rgb_pipe.sv
// Bench for phase_to_rgb_pipe: directed vector table, stall/reset sequences, and random traffic
// checked through an expected-output queue fed by an arithmetic reference model.
module tb_phase_to_rgb_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_phase;
    logic [7:0] in_value;
    logic       in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_red, out_green, out_blue;
    logic       err_range;

    always #5 clk = ~clk;

    phase_to_rgb_pipe #(
        .PHASE_W  (9),
        .PHASE_MAX(360),
        .COLOR_W  (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_phase (in_phase),
        .in_value (in_value),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_red  (out_red),
        .out_green(out_green),
        .out_blue (out_blue),
        .err_range(err_range)
    );

    typedef struct {
        int r;
        int g;
        int b;
    } rgb_t;

    typedef struct {
        int   ph;
        int   val;
        int   md;
        rgb_t e;
    } vec_t;

    rgb_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   emitted  = 0;
    logic held     = 1'b0;
    logic last_accept;
    logic seen_valid;
    int   held_r, held_g, held_b;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: hue wheel of three linear ramps, then brightness scaling.
    function automatic rgb_t model(input int ph, input int val, input int md);
        rgb_t o;
        int   p, s, x;
        p = (ph < 360) ? ph : 359;
        s = (p * 255) / 360;
        if (md != 0) begin
            o.r = s; o.g = s; o.b = s;
        end else if (s < 85) begin
            x = 3 * s;         o.r = 255 - x; o.g = x;       o.b = 0;
        end else if (s < 170) begin
            x = 3 * (s - 85);  o.r = 0;       o.g = 255 - x; o.b = x;
        end else begin
            x = 3 * (s - 170); o.r = x;       o.g = 0;       o.b = 255 - x;
        end
        o.r = (o.r * val) / 255;
        o.g = (o.g * val) / 255;
        o.b = (o.b * val) / 255;
        return o;
    endfunction

    // One clock: caller sets inputs after a negedge; e is what the current beat should produce.
    task automatic cycle(input rgb_t e);
        rgb_t f;
        #1;
        check("in_ready", int'(in_ready), int'(!out_valid || out_ready));
        if (held) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_red", int'(out_red), held_r);
            check("hold_green", int'(out_green), held_g);
            check("hold_blue", int'(out_blue), held_b);
        end
        held   = out_valid && !out_ready && !rst;
        held_r = int'(out_red);
        held_g = int'(out_green);
        held_b = int'(out_blue);
        if (out_valid && out_ready) begin
            emitted++;
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                f = exp_q.pop_front();
                check("out_red", int'(out_red), f.r);
                check("out_green", int'(out_green), f.g);
                check("out_blue", int'(out_blue), f.b);
            end
        end
        last_accept = in_valid && in_ready && !rst;
        if (last_accept) exp_q.push_back(e);
        seen_valid = out_valid;
        @(negedge clk);
    endtask

    task automatic drive(input int ph, input int val, input int md);
        in_valid = 1'b1;
        in_phase = 9'(ph);
        in_value = 8'(val);
        in_mode  = md[0];
    endtask

    vec_t tbl[8];
    rgb_t e;
    rgb_t none;
    int   acc, c, lat, ph, val, md;

    initial begin
        none = '{0, 0, 0};
        tbl[0] = '{0,   255, 0, '{255, 0,   0}};
        tbl[1] = '{120, 255, 0, '{0,   255, 0}};
        tbl[2] = '{240, 255, 0, '{0,   0,   255}};
        tbl[3] = '{60,  255, 0, '{129, 126, 0}};
        tbl[4] = '{359, 255, 0, '{252, 0,   3}};
        tbl[5] = '{0,   128, 0, '{128, 0,   0}};
        tbl[6] = '{180, 255, 1, '{127, 127, 127}};
        tbl[7] = '{400, 255, 0, '{252, 0,   3}};

        rst = 1'b1; in_valid = 1'b0; in_phase = '0; in_value = '0; in_mode = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_valid", int'(out_valid), 0);
        check("reset_red", int'(out_red), 0);
        check("reset_green", int'(out_green), 0);
        check("reset_blue", int'(out_blue), 0);
        check("reset_err", int'(err_range), 0);
        @(negedge clk);

        // Directed vectors back to back; drained after exactly 3 idle cycles means no bubbles.
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("err_before_oor", int'(err_range), 0);
            drive(tbl[i].ph, tbl[i].val, tbl[i].md);
            cycle(tbl[i].e);
        end
        in_valid = 1'b0;
        repeat (3) cycle(none);
        check("table_no_bubble", exp_q.size(), 0);
        check("err_after_oor", int'(err_range), 1);

        // Six beats with a four-cycle downstream stall mid-stream.
        acc = 0; c = 0; emitted = 0;
        ph = $urandom_range(0, 359); val = $urandom_range(0, 255); md = $urandom_range(0, 1);
        while ((acc < 6 || exp_q.size() > 0) && c < 40) begin
            out_ready = !(c >= 4 && c < 8);
            if (acc < 6) drive(ph, val, md);
            else in_valid = 1'b0;
            cycle(model(ph, val, md));
            if (last_accept) begin
                acc++;
                ph = $urandom_range(0, 359); val = $urandom_range(0, 255);
                md = $urandom_range(0, 1);
            end
            c++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stall_accepted", acc, 6);
        check("stall_emitted", emitted, 6);
        check("stall_drained", exp_q.size(), 0);
        check("err_sticky", int'(err_range), 1);

        // Reset with beats in flight.
        for (int i = 0; i < 3; i++) begin
            drive(30 * i + 10, 200, 0);
            cycle(model(30 * i + 10, 200, 0));
        end
        in_valid = 1'b0;
        rst = 1'b1;
        cycle(none);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_red", int'(out_red), 0);
        check("midrst_green", int'(out_green), 0);
        check("midrst_blue", int'(out_blue), 0);
        check("midrst_err", int'(err_range), 0);
        @(negedge clk);
        drive(0, 255, 0);
        cycle('{255, 0, 0});
        in_valid = 1'b0;
        lat = 0;
        seen_valid = 1'b0;
        while (!seen_valid && lat < 10) begin
            cycle(none);
            lat++;
        end
        check("post_reset_latency", lat, 3);
        check("post_reset_drained", exp_q.size(), 0);

        // Random traffic with random backpressure, including out-of-range phases.
        for (int i = 0; i < 400; i++) begin
            ph  = $urandom_range(0, 511);
            val = $urandom_range(0, 255);
            md  = $urandom_range(0, 3) == 0 ? 1 : 0;
            if ($urandom_range(0, 9) < 7) drive(ph, val, md);
            else in_valid = 1'b0;
            out_ready = $urandom_range(0, 9) < 7;
            cycle(model(ph, val, md));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        c = 0;
        while (exp_q.size() > 0 && c < 20) begin
            cycle(none);
            c++;
        end
        check("random_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
